// File: rtl/song_pkg.sv
// Shared definitions for the song recorder and the song player:
// field widths, special note codes, record layout and recorder states.
package song_pkg;

  localparam int NKEYS  = 8;
  localparam int NOTE_W = 4;
  localparam int DUR_W  = 12;
  localparam int ADDR_W = 8;

  localparam logic [3:0] REST      = 4'h0;
  localparam logic [3:0] TERM_CODE = 4'hF;

  // Record layout is {note, dur}: duration in the low bits, note above it.
  localparam int REC_W    = NOTE_W + DUR_W;
  localparam int DUR_LSB  = 0;
  localparam int DUR_MSB  = DUR_W - 1;
  localparam int NOTE_LSB = DUR_W;
  localparam int NOTE_MSB = DUR_W + NOTE_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_KEY = 3'd1,
    ST_RECORD   = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_TERM     = 3'd4
  } rec_state_e;

endpackage

// File: rtl/key_note_encoder.sv
// Priority encoder from the debounced key bus to a note code.
// The lowest pressed key wins and gives code index+1; no key gives a rest.
module key_note_encoder #(
  parameter int NKEYS  = 8,
  parameter int NOTE_W = 4
) (
  input  logic [NKEYS-1:0]  keys,
  output logic [NOTE_W-1:0] note
);
  import song_pkg::*;

  // Scan from the top down so the lowest set key is the last to assign.
  always_comb begin
    note = NOTE_W'(REST);
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (keys[i]) note = NOTE_W'(i + 1);
    end
  end

endmodule

// File: rtl/song_recorder.sv
// Song recorder: samples the note keys on every tick and writes run-length
// {note, dur} records to song RAM, ending each song with a terminator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not recording; waits for rec_start
// WAIT_KEY | armed; leading silence is discarded until the first note
// RECORD   | accumulating the duration of cur_note, one count per tick
// FLUSH    | writes the record still in progress after rec_stop
// TERM     | writes the terminator, latches song_len, pulses done
module song_recorder #(
  parameter int NKEYS  = song_pkg::NKEYS,
  parameter int NOTE_W = song_pkg::NOTE_W,
  parameter int DUR_W  = song_pkg::DUR_W,
  parameter int ADDR_W = song_pkg::ADDR_W
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    rec_start,
  input  logic                    rec_stop,
  input  logic [NKEYS-1:0]        keys,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [NOTE_W+DUR_W-1:0] wr_data,
  output logic                    busy,
  output logic                    full,
  output logic                    done,
  output logic [ADDR_W:0]         song_len
);
  import song_pkg::*;

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_DATA = ADDR_W'(DEPTH - 2);
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;

  rec_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [NOTE_W-1:0]       cur_note_q, cur_note_d;
  logic [DUR_W-1:0]        dur_q, dur_d;
  logic                    full_q, full_d;
  logic                    done_q, done_d;
  logic [ADDR_W:0]         song_len_q, song_len_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [NOTE_W+DUR_W-1:0] wr_data_q, wr_data_d;

  logic [NOTE_W-1:0] note;
  logic              rec_write;
  logic              at_last;

  key_note_encoder #(.NKEYS(NKEYS), .NOTE_W(NOTE_W)) u_enc (
    .keys (keys),
    .note (note)
  );

  // A record closes on a note change or a saturated duration; stop pre-empts it.
  assign rec_write = (state_q == ST_RECORD) && !rec_stop && tick &&
                     ((note != cur_note_q) || (dur_q == DUR_MAX));
  assign at_last   = (addr_q == LAST_DATA);

  // State and datapath registers, cleared asynchronously so a reset aborts at once.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cur_note_q <= '0;
      dur_q      <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      song_len_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cur_note_q <= cur_note_d;
      dur_q      <= dur_d;
      full_q     <= full_d;
      done_q     <= done_d;
      song_len_q <= song_len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rec_start) state_d = ST_WAIT_KEY;
      ST_WAIT_KEY: begin
        if (rec_stop)                         state_d = ST_TERM;
        else if (tick && (note != NOTE_W'(REST))) state_d = ST_RECORD;
      end
      ST_RECORD: begin
        if (rec_stop)                state_d = ST_FLUSH;
        else if (rec_write && at_last) state_d = ST_TERM;
      end
      ST_FLUSH:    state_d = ST_TERM;
      ST_TERM:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered write-port values for each state.
  always_comb begin
    addr_d     = addr_q;
    cur_note_d = cur_note_q;
    dur_d      = dur_q;
    full_d     = full_q;
    song_len_d = song_len_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          addr_d = '0;
          full_d = 1'b0;
        end
      end
      ST_WAIT_KEY: begin
        if (!rec_stop && tick && (note != NOTE_W'(REST))) begin
          cur_note_d = note;
          dur_d      = DUR_W'(1);
        end
      end
      ST_RECORD: begin
        if (rec_write) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = {cur_note_q, dur_q};
          addr_d     = addr_q + ADDR_W'(1);
          cur_note_d = note;
          dur_d      = DUR_W'(1);
          if (at_last) full_d = 1'b1;
        end else if (!rec_stop && tick) begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      ST_FLUSH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = {cur_note_q, dur_q};
        addr_d    = addr_q + ADDR_W'(1);
        if (at_last) full_d = 1'b1;
      end
      ST_TERM: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = addr_q;
        wr_data_d  = {NOTE_W'(TERM_CODE), {DUR_W{1'b0}}};
        song_len_d = {1'b0, addr_q} + (ADDR_W + 1)'(1);
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign full     = full_q;
  assign done     = done_q;
  assign song_len = song_len_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: a default build (A), a DUR_W=4 build (B)
// and an ADDR_W=3 build (C) share one stimulus bus; each test checks one build.
module tb_song_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rec_start = 1'b0;
  logic       rec_stop = 1'b0;
  logic [7:0] keys = 8'h00;

  logic        wr_en_a, busy_a, full_a, done_a;
  logic [7:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic [8:0]  song_len_a;

  logic        wr_en_b, busy_b, full_b, done_b;
  logic [7:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [8:0]  song_len_b;

  logic        wr_en_c, busy_c, full_c, done_c;
  logic [2:0]  wr_addr_c;
  logic [15:0] wr_data_c;
  logic [3:0]  song_len_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  qa_a[$];
  logic [15:0] qa_d[$];
  logic [7:0]  qb_a[$];
  logic [7:0]  qb_d[$];
  logic [2:0]  qc_a[$];
  logic [15:0] qc_d[$];
  int da = 0, db = 0, dc = 0;
  int busy_at_done_a = 0;

  always #5 clk = ~clk;

  song_recorder u_a (
    .sys_clk(clk), .rst(rst), .tick(tick), .rec_start(rec_start), .rec_stop(rec_stop),
    .keys(keys), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .full(full_a), .done(done_a), .song_len(song_len_a)
  );

  song_recorder #(.DUR_W(4)) u_b (
    .sys_clk(clk), .rst(rst), .tick(tick), .rec_start(rec_start), .rec_stop(rec_stop),
    .keys(keys), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .full(full_b), .done(done_b), .song_len(song_len_b)
  );

  song_recorder #(.ADDR_W(3)) u_c (
    .sys_clk(clk), .rst(rst), .tick(tick), .rec_start(rec_start), .rec_stop(rec_stop),
    .keys(keys), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .busy(busy_c), .full(full_c), .done(done_c), .song_len(song_len_c)
  );

  // Log every RAM write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_a) begin qa_a.push_back(wr_addr_a); qa_d.push_back(wr_data_a); end
    if (wr_en_b) begin qb_a.push_back(wr_addr_b); qb_d.push_back(wr_data_b); end
    if (wr_en_c) begin qc_a.push_back(wr_addr_c); qc_d.push_back(wr_data_c); end
    if (done_a) begin da++; if (busy_a) busy_at_done_a++; end
    if (done_b) db++;
    if (done_c) dc++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    qa_a.delete(); qa_d.delete();
    qb_a.delete(); qb_d.delete();
    qc_a.delete(); qc_d.delete();
    da = 0; db = 0; dc = 0;
    busy_at_done_a = 0;
  endtask

  task automatic do_tick(input logic [7:0] k);
    keys = k;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic start_rec();
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    cyc();
  endtask

  task automatic stop_rec();
    rec_stop = 1'b1;
    cyc();
    rec_stop = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({wr_en_a, busy_a, full_a, done_a} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags_a got %b want 0000", {wr_en_a, busy_a, full_a, done_a}); end
    n_cmp++; if ({wr_addr_a, wr_data_a, song_len_a} !== 33'b0) begin n_bad++;
      $display("FAIL reset_bus_a got %h want 0", {wr_addr_a, wr_data_a, song_len_a}); end
    n_cmp++; if ({wr_en_c, busy_c, full_c, done_c, song_len_c} !== 8'b0) begin n_bad++;
      $display("FAIL reset_c got %h want 0", {wr_en_c, busy_c, full_c, done_c, song_len_c}); end
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_note();
    logic [15:0] exp [3] = '{16'h3005, 16'h0003, 16'hF000};
    clear_logs();
    start_rec();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy_a); end
    repeat (5) do_tick(8'b0000_0100);
    repeat (3) do_tick(8'b0000_0000);
    stop_rec();
    n_cmp++; if (qa_d.size() !== 3) begin n_bad++; $display("FAIL single_count got %0d want 3", qa_d.size()); end
    for (int i = 0; i < 3 && i < qa_d.size(); i++) begin
      n_cmp++; if (qa_d[i] !== exp[i] || qa_a[i] !== 8'(i)) begin n_bad++;
        $display("FAIL single_rec%0d got %h@%0d want %h@%0d", i, qa_d[i], qa_a[i], exp[i], i); end
    end
    n_cmp++; if (song_len_a !== 9'd3) begin n_bad++; $display("FAIL single_len got %0d want 3", song_len_a); end
    n_cmp++; if (da !== 1) begin n_bad++; $display("FAIL single_done got %0d want 1", da); end
    n_cmp++; if (busy_at_done_a !== 0 || busy_a !== 1'b0) begin n_bad++;
      $display("FAIL single_busy_fall got %0d/%b want 0/0", busy_at_done_a, busy_a); end
  endtask

  task automatic test_empty_song();
    clear_logs();
    start_rec();
    repeat (10) do_tick(8'h00);
    stop_rec();
    n_cmp++; if (qa_d.size() !== 1) begin n_bad++; $display("FAIL empty_count got %0d want 1", qa_d.size()); end
    if (qa_d.size() > 0) begin
      n_cmp++; if (qa_d[0] !== 16'hF000 || qa_a[0] !== 8'd0) begin n_bad++;
        $display("FAIL empty_term got %h@%0d want f000@0", qa_d[0], qa_a[0]); end
    end
    n_cmp++; if (song_len_a !== 9'd1) begin n_bad++; $display("FAIL empty_len got %0d want 1", song_len_a); end
  endtask

  task automatic test_priority();
    logic [15:0] exp [3] = '{16'h2004, 16'h3002, 16'hF000};
    clear_logs();
    start_rec();
    repeat (4) do_tick(8'b0000_0110);
    repeat (2) do_tick(8'b0000_0100);
    stop_rec();
    n_cmp++; if (qa_d.size() !== 3) begin n_bad++; $display("FAIL prio_count got %0d want 3", qa_d.size()); end
    for (int i = 0; i < 3 && i < qa_d.size(); i++) begin
      n_cmp++; if (qa_d[i] !== exp[i] || qa_a[i] !== 8'(i)) begin n_bad++;
        $display("FAIL prio_rec%0d got %h@%0d want %h@%0d", i, qa_d[i], qa_a[i], exp[i], i); end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp [3] = '{8'h1F, 8'h15, 8'hF0};
    clear_logs();
    start_rec();
    repeat (20) do_tick(8'b0000_0001);
    stop_rec();
    n_cmp++; if (qb_d.size() !== 3) begin n_bad++; $display("FAIL sat_count got %0d want 3", qb_d.size()); end
    for (int i = 0; i < 3 && i < qb_d.size(); i++) begin
      n_cmp++; if (qb_d[i] !== exp[i] || qb_a[i] !== 8'(i)) begin n_bad++;
        $display("FAIL sat_rec%0d got %h@%0d want %h@%0d", i, qb_d[i], qb_a[i], exp[i], i); end
    end
    n_cmp++; if (song_len_b !== 9'd3) begin n_bad++; $display("FAIL sat_len got %0d want 3", song_len_b); end
  endtask

  task automatic test_full();
    logic [15:0] want;
    clear_logs();
    start_rec();
    for (int t = 0; t < 10; t++) do_tick((t % 2 == 0) ? 8'b0000_0001 : 8'b0000_0010);
    n_cmp++; if (qc_d.size() !== 8) begin n_bad++; $display("FAIL full_count got %0d want 8", qc_d.size()); end
    for (int i = 0; i < 8 && i < qc_d.size(); i++) begin
      want = (i == 7) ? 16'hF000 : ((i % 2 == 0) ? 16'h1001 : 16'h2001);
      n_cmp++; if (qc_d[i] !== want || qc_a[i] !== 3'(i)) begin n_bad++;
        $display("FAIL full_rec%0d got %h@%0d want %h@%0d", i, qc_d[i], qc_a[i], want, i); end
    end
    n_cmp++; if (full_c !== 1'b1 || song_len_c !== 4'd8 || busy_c !== 1'b0) begin n_bad++;
      $display("FAIL full_flags got full=%b len=%0d busy=%b want 1/8/0", full_c, song_len_c, busy_c); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL full_done got %0d want 1", dc); end
    stop_rec();
    n_cmp++; if (qc_d.size() !== 8 || dc !== 1 || full_c !== 1'b1) begin n_bad++;
      $display("FAIL full_stop_ignored got writes=%0d done=%0d full=%b want 8/1/1", qc_d.size(), dc, full_c); end
    start_rec();
    n_cmp++; if (full_c !== 1'b0 || busy_c !== 1'b1) begin n_bad++;
      $display("FAIL full_clear got full=%b busy=%b want 0/1", full_c, busy_c); end
    stop_rec();
  endtask

  task automatic test_collision();
    clear_logs();
    start_rec();
    repeat (3) do_tick(8'b0000_0001);
    keys = 8'b0000_0001;
    tick = 1'b1;
    rec_stop = 1'b1;
    cyc();
    tick = 1'b0;
    rec_stop = 1'b0;
    repeat (4) cyc();
    n_cmp++; if (qa_d.size() !== 2) begin n_bad++; $display("FAIL coll_count got %0d want 2", qa_d.size()); end
    if (qa_d.size() == 2) begin
      n_cmp++; if (qa_d[0] !== 16'h1003 || qa_d[1] !== 16'hF000) begin n_bad++;
        $display("FAIL coll_recs got %h,%h want 1003,f000", qa_d[0], qa_d[1]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start_rec();
    repeat (3) do_tick(8'b0000_0001);
    keys = 8'b0000_0010;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_cmp++; if (wr_en_a !== 1'b1 || wr_data_a !== 16'h1003) begin n_bad++;
      $display("FAIL rstmid_pre got en=%b data=%h want 1/1003", wr_en_a, wr_data_a); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({wr_en_a, busy_a, full_a, done_a} !== 4'b0 || wr_data_a !== 16'h0 || song_len_a !== 9'd0) begin n_bad++;
      $display("FAIL rstmid_async got en=%b busy=%b data=%h len=%0d want 0", wr_en_a, busy_a, wr_data_a, song_len_a); end
    cyc(); cyc();
    rst = 1'b0;
    clear_logs();
    do_tick(8'b0000_0001);
    do_tick(8'b0000_0010);
    do_tick(8'b0000_0000);
    stop_rec();
    n_cmp++; if (qa_d.size() !== 0 || da !== 0 || busy_a !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_after got writes=%0d done=%0d busy=%b want 0/0/0", qa_d.size(), da, busy_a); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_empty_song();
    test_priority();
    test_saturation();
    test_full();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Captures what the player performs on the eight note keys and writes it to song RAM as a sequence of (note, duration) records.
- Output format is the one the song player reads back for Play, Learn and Game modes, so this block is the writer end of the song-memory interface.
- Sits beside the free-mode player: same debounced key bus, same slow timing tick, drives the RAM write port.

Parameters:
- NKEYS, 8, number of note keys.
- NOTE_W, 4, note code width.
- DUR_W, 12, duration field width, in ticks.
- ADDR_W, 8, song RAM address width; DEPTH = 2**ADDR_W records.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick  in  1  one-cycle timing strobe (slow_clk rate); all note sampling happens on tick.
- rec_start  in  1  one-cycle pulse (center posedge); arms recording.
- rec_stop  in  1  one-cycle pulse (esc posedge); ends recording.
- keys  in  NKEYS  debounced pressed state; bit i = key i held.
- wr_en  out  1  RAM write strobe, one cycle per record.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  NOTE_W+DUR_W  record {note, dur}.
- busy  out  1  high in any state other than IDLE.
- full  out  1  sticky; RAM filled before stop; cleared by the next accepted rec_start.
- done  out  1  one-cycle pulse after the terminator is written.
- song_len  out  ADDR_W+1  records written including the terminator; latched on done.

Behaviour:
- Reset: state IDLE; all outputs 0; internal address, cur_note and dur counters 0.
- Note encoding (combinational) from keys:
  - lowest set index i gives note = i+1 (codes 1..8).
  - no key gives note = 0 (rest).
  - Codes 9..14 unused. 15 = TERM marker.
- States: IDLE, WAIT_KEY, RECORD, FLUSH, TERM.
- IDLE:
  - rec_start: addr <= 0, full <= 0, go to WAIT_KEY.
  - rec_stop is ignored.
- WAIT_KEY (leading silence is discarded):
  - tick with note != 0: cur_note <= note, dur <= 1, go to RECORD.
  - rec_stop: go to TERM.
- RECORD, on tick:
  - If note != cur_note or dur == 2**DUR_W-1: write {cur_note, dur} at addr, addr++, cur_note <= note, dur <= 1.
  - Otherwise dur++.
  - A saturated duration is therefore split into consecutive records with the same note.
  - Rests (note 0) are recorded like notes.
- RECORD, rec_stop: go to FLUSH. Stop wins over a same-cycle tick, and that tick is discarded.
- FLUSH: write {cur_note, dur} at addr, addr++, go to TERM. Exactly 1 cycle.
- TERM:
  - write {4'hF, 0} at addr, song_len <= addr+1, pulse done, go to IDLE. Exactly 1 cycle.
  - Trailing rest is kept (it was flushed as a record).
- Full handling:
  - Data records may occupy addresses 0..DEPTH-2; DEPTH-1 is reserved for the terminator.
  - A data write at addr DEPTH-2 (RECORD or FLUSH) sets full and goes to TERM next cycle, skipping FLUSH.
- Write timing:
  - wr_en/wr_addr/wr_data are registered; they are valid in the cycle after the causing tick/state.
  - wr_en is never high on two records with the same address.
- rec_start while busy is ignored.
- rst mid-recording aborts immediately. No terminator is written; RAM contents are undefined to readers.
- Width rules:
  - dur never wraps; it saturates via the split rule.
  - addr never exceeds DEPTH-1.

Decomposition:
- Shared package song_pkg holds:
  - NOTE_W, DUR_W, REST=0, TERM_CODE=15.
  - record field positions.
  - recorder state encoding.
- song_pkg is shared with the song player.
- One sub-module: key_note_encoder. Purely combinational priority encoder, keys -> note.

Test Plan:
- Single note. rec_start; key2 held 5 ticks then released; 3 rest ticks; rec_stop.
  - Required writes: addr0 {3,5}, addr1 {0,3}, addr2 {F,0}.
  - song_len = 3, done pulses once, busy falls with done.
- Leading silence, empty song. rec_start; 10 rest ticks; rec_stop.
  - Required: only addr0 {F,0}; song_len = 1.
- Priority and change. keys 8'b0000_0110 for 4 ticks, then 8'b0000_0100 for 2 ticks; stop.
  - Required: {2,4}, {3,2}, {F,0}.
- Saturation. Test build with DUR_W=4; key0 held 20 ticks; stop.
  - Required: {1,15}, {1,5}, {F,0}.
- Full. Test build with ADDR_W=3; alternate key0/key1 every tick.
  - Required: records at addr 0..6, then terminator at addr 7.
  - full = 1, song_len = 8; later rec_stop is ignored.
  - Next rec_start clears full.
- Stop/tick collision and reset.
  - rec_stop coincident with tick in RECORD (dur=3): flushed record shows dur=3, not 4.
  - rst asserted mid-RECORD: outputs 0 asynchronously, state IDLE, no further wr_en.
